// File: rtl/axi4l_pkg.sv
// AXI4-Lite shared types: address/data/strobe widths and response encodings.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle; clock and synchronous active-low reset travel with the bus.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/obi_axi4l_master.sv
// OBI data port to AXI4-Lite master bridge, one transaction outstanding; AXI4L_MASTER_ADDR_CHECK_EN rejects out-of-window addresses.
// Latency: grant to data_rvalid is 3 cycles with a zero-wait slave (1 cycle for a rejected address).
// Backpressure: data_gnt only in IDLE; AXI valids are held until the slave accepts, with no timeout.
module obi_axi4l_master
  import axi4l_pkg::*;
#(
  parameter addr_t       ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  axi4l_if.master axi,
  input  logic    data_req,
  output logic    data_gnt,
  input  logic    data_we,
  input  strb_t   data_be,
  input  addr_t   data_addr,
  input  data_t   data_wdata,
  output logic    data_rvalid,
  output data_t   data_rdata,
  output logic    data_err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  state_e r_state;
  addr_t  r_addr;
  strb_t  r_be;
  data_t  r_wdata;
  logic   r_awvalid;
  logic   r_wvalid;
  logic   r_bready;
  logic   r_arvalid;
  logic   r_rready;
  logic   r_rvalid;
  logic   r_err;
  data_t  r_rdata;
  logic   w_addr_ok;

`ifdef AXI4L_MASTER_ADDR_CHECK_EN
  // 33-bit compare so a window ending exactly at 2^32 does not wrap
  logic [32:0] w_addr33;
  logic [32:0] w_win_lo;
  logic [32:0] w_win_hi;
  assign w_addr33  = {1'b0, data_addr};
  assign w_win_lo  = {1'b0, ADDR_BASE};
  assign w_win_hi  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
  assign w_addr_ok = (w_addr33 >= w_win_lo) && (w_addr33 < w_win_hi);
`else
  assign w_addr_ok = 1'b1;
`endif

  assign data_gnt = data_req && (r_state == IDLE);

  always_ff @(posedge axi.aclk) begin
    if (!axi.aresetn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_req) begin
            r_addr  <= data_addr;
            r_be    <= data_be;
            r_wdata <= data_wdata;
            if (!w_addr_ok) begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
            end else if (data_we) begin
              r_state   <= WRITE;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
            end else begin
              r_state   <= READ;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi.wready)   r_wvalid  <= 1'b0;
          // B ends the transaction; clear AW/W too so nothing leaks into IDLE
          if (r_bready && axi.bvalid) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_err     <= (axi.bresp != OKAY);
            r_rdata   <= '0;
            r_rvalid  <= 1'b1;
            r_state   <= RESP;
          end
        end
        READ: begin
          if (r_arvalid && axi.arready) r_arvalid <= 1'b0;
          if (r_rready && axi.rvalid) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_err     <= (axi.rresp != OKAY);
            r_rdata   <= axi.rdata;
            r_rvalid  <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign axi.awaddr  = r_addr;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_be;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.araddr  = r_addr;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  assign data_rvalid = r_rvalid;
  assign data_rdata  = r_rdata;
  assign data_err    = r_err;

endmodule

// File: doc/obi_axi4l_master.md
Name: obi_axi4l_master

Overview:
- Converts the Ibex LSU/OBI-style data request interface into an AXI4-Lite master.
- Sits between the Ibex core data port and the SoC AXI4-Lite interconnect, upstream of the RAM and peripheral slaves.
- One transaction outstanding at a time; the AW and W channels are issued together and may complete independently.

Parameters:
- ADDR_BASE, 32'h0000_0000, base of legal address window (used only with AXI4L_MASTER_ADDR_CHECK_EN).
- ADDR_SIZE, 32'h0001_0000, size in bytes of legal window (used only with AXI4L_MASTER_ADDR_CHECK_EN).

Ports:
- axi.aclk  input  1  clock, carried in axi4l_if.
- axi.aresetn  input  1  synchronous active-low reset, carried in axi4l_if.
- axi  modport  -  axi4l_if.master: aw*, w*, b*, ar*, r* channels; widths from axi4l_pkg addr_t/data_t/strb_t.
- data_req  input  1  request valid.
- data_gnt  output  1  request accepted (combinational).
- data_we  input  1  1 = write, 0 = read.
- data_be  input  4  byte enables.
- data_addr  input  32  byte address.
- data_wdata  input  32  write data.
- data_rvalid  output  1  one-cycle response pulse.
- data_rdata  output  32  read data, valid with data_rvalid.
- data_err  output  1  error response, valid with data_rvalid.

Behaviour:
- Reset (axi.aresetn low at a clock edge):
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready, data_rvalid and data_err are driven 0; data_rdata is driven 0.
  - Any in-flight AXI transaction is abandoned; reset is system-wide.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - data_gnt = data_req, combinationally; data_gnt is 0 in every other state.
  - On grant, register addr, we, be and wdata.
  - We=1: next state WRITE, with awvalid=1, wvalid=1, bready=1 asserted from the next cycle.
  - We=0: next state READ, with arvalid=1, rready=1 asserted from the next cycle.
- Write channel drive (WRITE):
  - awaddr = registered addr; wdata = registered wdata; wstrb = registered be.
  - awvalid drops the cycle after awready&&awvalid; wvalid drops the cycle after wready&&wvalid; the two are independent.
  - Neither valid depends combinationally on a ready.
  - If bvalid&&bready occurs: bready drops and the state goes to RESP. This completes the transaction; the bench checks that it occurs only after both AW and W have handshaken.
  - data_err is registered as (bresp != OKAY); data_rdata is registered as 0.
- Read channel drive (READ):
  - araddr = registered addr.
  - arvalid drops after arready&&arvalid.
  - On rvalid&&rready: register rdata into data_rdata, register data_err = (rresp != OKAY), drop rready, go to RESP.
- RESP: data_rvalid = 1 for exactly one cycle, then IDLE.
- Back-to-back:
  - The earliest new grant is in the cycle after RESP.
  - Minimum latency from grant to data_rvalid is 3 cycles, with a zero-wait slave.
- Valid/payload stability: awaddr, wdata, wstrb and araddr are stable while the corresponding valid is high.
- Simultaneous events:
  - awready and wready in the same cycle: both valids drop together.
  - bvalid arriving in the same cycle as the last of AW/W completing is accepted.
- Stalls: slave readies held low indefinitely keep the block in WRITE/READ with valids held. There is no timeout.
- data_req deasserted while not granted: no effect.

Optional Feature:
- Macro: AXI4L_MASTER_ADDR_CHECK_EN.
- Defined:
  - A request with addr < ADDR_BASE or addr >= ADDR_BASE+ADDR_SIZE is granted normally but issues no AXI traffic.
  - Next state is RESP directly, with data_err=1 and data_rdata=0.
  - The comparison is unsigned 33-bit, so ADDR_BASE+ADDR_SIZE = 2^32 does not wrap.
- Undefined: all addresses are forwarded; ADDR_BASE and ADDR_SIZE are ignored.

Decomposition:
- axi4l_pkg already supplies addr_t, data_t, strb_t and the resp_t encodings (OKAY, SLVERR, …); no new package.
- The state enum is local to the module.
- No sub-module; the address-window check is a few lines of combinational logic in the module body.

Test Plan:
- Write addr 32'h0000_0010, be 4'hF, wdata 32'hDEAD_BEEF; slave readies always 1 -> AW/W handshake 1 cycle after grant, data_rvalid pulse 3 cycles after grant, data_err=0.
- Read addr 32'h0000_0010 after that write -> araddr 32'h10 issued; data_rdata=32'hDEAD_BEEF with data_rvalid pulse; data_err=0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid high 1 cycle, awvalid high 4 cycles; single data_rvalid after B.
- Read with rresp=SLVERR, rdata=32'h1234_5678 -> data_rvalid=1, data_err=1, data_rdata=32'h1234_5678.
- Reset asserted while in WRITE with awvalid=1 -> next cycle all valids 0, state IDLE, data_req=1 granted the following cycle.
- With AXI4L_MASTER_ADDR_CHECK_EN, ADDR_BASE=0, ADDR_SIZE=32'h80: read 32'h80 -> no arvalid ever, data_rvalid one cycle after grant with data_err=1 and data_rdata=0.
